// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, byte-wide synchronous memory between the core's
// instruction-fetch port (rom_*) and data port (ram_*). Every 32-bit access is
// split into four little-endian byte cycles. The data port always wins when
// both ports request in the same idle cycle.
//
// Timing relative to the accept cycle (cycle 0, IDLE with a ce high):
//   load/fetch : byte addresses in cycles 1..4, address held in cycle 5,
//                mem_din_i captured at the end of cycles 2..5, ready in cycle 6
//   store      : byte writes in cycles 1..4, ready in cycle 5
//   DONE always lasts exactly one cycle and never accepts a new request.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rom_ce_i        fetch request (held until rom_ready_o)
//   rom_addr_i      fetch byte address (upper 32-ADDR_W bits ignored)
//   rom_data_o      fetched word, qualified by rom_ready_o, otherwise held
//   rom_ready_o     one-cycle fetch completion pulse
//   ram_ce_i        data request (held until ram_ready_o)
//   ram_w_enable_i  1 = store, 0 = load
//   ram_addr_i      data byte address (upper 32-ADDR_W bits ignored)
//   ram_w_data_i    store data
//   ram_sel_i       store byte enables, bit k = byte k (ignored for loads)
//   ram_r_data_o    load word, qualified by ram_ready_o (0 after a store)
//   ram_ready_o     one-cycle data completion pulse
//   mem_addr_o      external byte address
//   mem_din_i       external read byte, one cycle after its address
//   mem_dout_o      external write byte
//   mem_wr_o        external write strobe
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              rom_ready_o,
    input  logic              ram_ce_i,
    input  logic              ram_w_enable_i,
    input  logic [31:0]       ram_addr_i,
    input  logic [31:0]       ram_w_data_i,
    input  logic [3:0]        ram_sel_i,
    output logic [31:0]       ram_r_data_o,
    output logic              ram_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_din_i,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              src_q, src_d;          // 1 = data port owns the access
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic [23:0]       word_q, word_d;        // byte lanes 0..2; lane 3 goes straight out
    logic [31:0]       rom_data_q, rom_data_d;
    logic [31:0]       ram_rdata_q, ram_rdata_d;

    // Upper request address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W], ram_addr_i[31:ADDR_W]};

    // Store data split into byte lanes for the write mux.
    logic [7:0] wr_lane [4];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_lane
            assign wr_lane[gi] = wdata_q[8*gi +: 8];
        end
    endgenerate

    // During the final read cycle (cnt=4) the address stays on byte 3.
    logic [1:0] byte_off;
    assign byte_off = cnt_q[2] ? 2'd3 : cnt_q[1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ram_ce_i) begin
                    state_d = ram_w_enable_i ? WR : RD;
                end else if (rom_ce_i) begin
                    state_d = RD;
                end
            end
            RD:      if (cnt_q == 3'd4) state_d = DONE;
            WR:      if (cnt_q == 3'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_addr_o  = '0;
        mem_wr_o    = 1'b0;
        mem_dout_o  = 8'd0;
        rom_ready_o = 1'b0;
        ram_ready_o = 1'b0;
        case (state_q)
            RD: begin
                mem_addr_o = base_q + {{(ADDR_W-2){1'b0}}, byte_off};
            end
            WR: begin
                mem_addr_o = base_q + {{(ADDR_W-2){1'b0}}, byte_off};
                mem_dout_o = wr_lane[cnt_q[1:0]];
                // Reset kills the strobe in the very cycle it is asserted so an
                // aborted store writes nothing past the bytes already done.
                mem_wr_o   = sel_q[cnt_q[1:0]] & ~rst;
            end
            DONE: begin
                rom_ready_o = ~src_q;
                ram_ready_o = src_q;
            end
            default: ;
        endcase
    end

    // ---------------- Datapath: next values ----------------
    always_comb begin
        cnt_d       = cnt_q;
        src_d       = src_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        word_d      = word_q;
        rom_data_d  = rom_data_q;
        ram_rdata_d = ram_rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (ram_ce_i) begin
                    src_d   = 1'b1;
                    base_d  = ram_addr_i[ADDR_W-1:0];
                    wdata_d = ram_w_data_i;
                    sel_d   = ram_sel_i;
                end else if (rom_ce_i) begin
                    src_d  = 1'b0;
                    base_d = rom_addr_i[ADDR_W-1:0];
                end
            end
            RD: begin
                cnt_d = cnt_q + 3'd1;
                // mem_din_i lags the address by one cycle, so the byte seen
                // while cnt=n belongs to lane n-1.
                case (cnt_q)
                    3'd1: word_d[7:0]   = mem_din_i;
                    3'd2: word_d[15:8]  = mem_din_i;
                    3'd3: word_d[23:16] = mem_din_i;
                    3'd4: begin
                        if (src_q) begin
                            ram_rdata_d = {mem_din_i, word_q};
                        end else begin
                            rom_data_d  = {mem_din_i, word_q};
                        end
                    end
                    default: ;
                endcase
            end
            WR: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd3) begin
                    ram_rdata_d = 32'd0;
                end
            end
            default: ;
        endcase
    end

    // ---------------- Datapath: registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 3'd0;
            src_q       <= 1'b0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            sel_q       <= 4'd0;
            word_q      <= 24'd0;
            rom_data_q  <= 32'd0;
            ram_rdata_q <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            word_q      <= word_d;
            rom_data_q  <= rom_data_d;
            ram_rdata_q <= ram_rdata_d;
        end
    end

    assign rom_data_o   = rom_data_q;
    assign ram_r_data_o = ram_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter against a byte-wide memory model. A transaction-level
// reference (timeline per accepted access plus a reference memory image)
// predicts every output each cycle; directed scenarios pin literal values.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          rom_ce;
    logic [31:0]   rom_addr;
    logic [31:0]   rom_data;
    logic          rom_ready;
    logic          ram_ce;
    logic          ram_we;
    logic [31:0]   ram_addr;
    logic [31:0]   ram_wd;
    logic [3:0]    ram_sel;
    logic [31:0]   ram_rdata;
    logic          ram_ready;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          mem_wr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce_i       (rom_ce),
        .rom_addr_i     (rom_addr),
        .rom_data_o     (rom_data),
        .rom_ready_o    (rom_ready),
        .ram_ce_i       (ram_ce),
        .ram_w_enable_i (ram_we),
        .ram_addr_i     (ram_addr),
        .ram_w_data_i   (ram_wd),
        .ram_sel_i      (ram_sel),
        .ram_r_data_o   (ram_rdata),
        .ram_ready_o    (ram_ready),
        .mem_addr_o     (mem_addr),
        .mem_din_i      (mem_din),
        .mem_dout_o     (mem_dout),
        .mem_wr_o       (mem_wr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External synchronous byte memory: read data appears one cycle later.
    bit [7:0] ext_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        mem_din <= ext_mem[mem_addr];
        if (mem_wr) ext_mem[mem_addr] <= mem_dout;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- Reference model ----------------
    bit [7:0]      ref_mem [0:(1<<AW)-1];
    bit            m_busy = 0;
    bit            m_store;
    bit            m_src;
    int            m_phase;
    logic [AW-1:0] m_base;
    logic [31:0]   m_wdata;
    logic [3:0]    m_sel;
    logic [31:0]   e_rom_data = 32'd0;
    logic [31:0]   e_ram_data = 32'd0;

    always @(negedge clk) begin
        logic [AW-1:0] e_addr;
        logic [AW-1:0] a0, a1, a2, a3;
        logic          e_wr, e_rr, e_fr, chk_addr;
        logic [7:0]    e_dout;
        logic [31:0]   w;
        int            last;
        if (cyc > 0) begin
            e_addr = '0; e_wr = 0; e_rr = 0; e_fr = 0; e_dout = 0; chk_addr = 1;
            if (m_busy) begin
                last = m_store ? 5 : 6;
                if (m_phase == last) begin
                    chk_addr = 0;
                    if (m_src) e_rr = 1; else e_fr = 1;
                    if (m_store) begin
                        e_ram_data = 32'd0;
                    end else begin
                        a0 = m_base; a1 = m_base + 17'd1; a2 = m_base + 17'd2; a3 = m_base + 17'd3;
                        w = {ref_mem[a3], ref_mem[a2], ref_mem[a1], ref_mem[a0]};
                        if (m_src) e_ram_data = w; else e_rom_data = w;
                    end
                end else if (m_store) begin
                    e_addr = m_base + AW'(m_phase - 1);
                    e_wr   = m_sel[m_phase - 1];
                    e_dout = m_wdata[8*(m_phase-1) +: 8];
                end else begin
                    e_addr = m_base + AW'((m_phase < 5) ? m_phase - 1 : 3);
                end
            end
            if (rst) e_wr = 0;
            if (chk_addr) chk("mem_addr", mem_addr, e_addr);
            chk("mem_wr", mem_wr, e_wr);
            if (e_wr) chk("mem_dout", mem_dout, e_dout);
            chk("rom_ready", rom_ready, e_fr);
            chk("ram_ready", ram_ready, e_rr);
            chk("rom_data", rom_data, e_rom_data);
            chk("ram_rdata", ram_rdata, e_ram_data);
            if (e_wr) ref_mem[e_addr] = e_dout;
        end
        if (rst) begin
            m_busy = 0;
            e_rom_data = 32'd0;
            e_ram_data = 32'd0;
        end else if (m_busy) begin
            if (m_phase == (m_store ? 5 : 6)) m_busy = 0;
            else m_phase++;
        end else if (ram_ce || rom_ce) begin
            m_busy  = 1;
            m_phase = 1;
            m_src   = ram_ce;
            m_store = ram_ce & ram_we;
            m_base  = ram_ce ? ram_addr[AW-1:0] : rom_addr[AW-1:0];
            m_wdata = ram_wd;
            m_sel   = ram_sel;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic do_req(input bit is_ram, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] sel,
                          output int lat, output logic [31:0] word,
                          output logic [4*AW-1:0] addrs, output logic [3:0] wrs);
        int t0;
        int k;
        bit got;
        @(posedge clk); #1;
        if (is_ram) begin
            ram_ce = 1; ram_we = we; ram_addr = addr; ram_wd = wd; ram_sel = sel;
        end else begin
            rom_ce = 1; rom_addr = addr;
        end
        t0 = cyc; got = 0; lat = -1; word = 0; addrs = '0; wrs = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            k = cyc - t0;
            if (k >= 1 && k <= 4) begin
                addrs[(k-1)*AW +: AW] = mem_addr;
                wrs[k-1] = mem_wr;
            end
            if (is_ram ? ram_ready : rom_ready) begin
                got = 1; lat = k;
                word = is_ram ? ram_rdata : rom_data;
            end
        end
        if (!got) chk("ready_timeout", 0, 1);
        $display("txn port=%s we=%0d addr=0x%08h wd=0x%08h sel=%b lat=%0d word=0x%08h",
                 is_ram ? "ram" : "rom", we, addr, wd, sel, lat, word);
        @(posedge clk); #1;
        ram_ce = 0; rom_ce = 0;
    endtask

    task automatic do_pair(input bit we, input logic [31:0] raddr, input logic [31:0] wd,
                           input logic [3:0] sel, input logic [31:0] faddr,
                           output int ram_lat, output int rom_lat);
        int t0;
        bit got;
        @(posedge clk); #1;
        ram_ce = 1; ram_we = we; ram_addr = raddr; ram_wd = wd; ram_sel = sel;
        rom_ce = 1; rom_addr = faddr;
        t0 = cyc; ram_lat = -1; rom_lat = -1; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (ram_ready) begin got = 1; ram_lat = cyc - t0; end
        end
        if (!got) chk("pair_ram_timeout", 0, 1);
        @(posedge clk); #1;
        ram_ce = 0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (rom_ready) begin got = 1; rom_lat = cyc - t0; end
        end
        if (!got) chk("pair_rom_timeout", 0, 1);
        $display("txn pair we=%0d ram_addr=0x%08h rom_addr=0x%08h ram_lat=%0d rom_lat=%0d",
                 we, raddr, faddr, ram_lat, rom_lat);
        @(posedge clk); #1;
        rom_ce = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- Main sequence ----------------
    initial begin
        int lat, lat2, t0;
        bit got;
        logic [31:0] word, a, d;
        logic [4*AW-1:0] addrs;
        logic [3:0] wrs, s;
        int kind;

        // Reset held two cycles with both requests high.
        rst = 1; rom_ce = 1; ram_ce = 1; ram_we = 0;
        ram_addr = 32'h40; rom_addr = 32'h0; ram_wd = 0; ram_sel = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rom_ready", rom_ready, 0);
        chk("rst_ram_ready", ram_ready, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 0; t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        chk("first_accept_addr", mem_addr, 17'h40);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ram_ready) begin got = 1; chk("first_load_lat", cyc - t0, 6); end
        end
        if (!got) chk("first_load_timeout", 0, 1);
        @(posedge clk); #1;
        ram_ce = 0; rom_ce = 0;

        // Fetch of a known instruction word.
        do_req(1, 1, 32'h100, 32'h00500013, 4'b1111, lat, word, addrs, wrs);
        do_req(0, 0, 32'h100, 0, 0, lat, word, addrs, wrs);
        chk("fetch_lat", lat, 6);
        chk("fetch_word", word, 32'h00500013);
        chk("fetch_addrs", addrs, {17'h103, 17'h102, 17'h101, 17'h100});

        // Partial store then load-back.
        do_req(1, 1, 32'h200, 32'hAAAA0000, 4'b1100, lat, word, addrs, wrs);
        do_req(1, 1, 32'h200, 32'hDEADBEEF, 4'b0011, lat, word, addrs, wrs);
        chk("store_lat", lat, 5);
        chk("store_wrs", wrs, 4'b0011);
        chk("store_addrs", addrs[2*AW-1:0], {17'h201, 17'h200});
        chk("store_word_zero", word, 0);
        do_req(1, 0, 32'h200, 0, 4'b0001, lat, word, addrs, wrs);
        chk("loadback_word", word, 32'hAAAABEEF);

        // Simultaneous requests: data first, fetch right after.
        do_pair(0, 32'h300, 0, 4'b0000, 32'h100, lat, lat2);
        chk("pair_ram_lat", lat, 6);
        chk("pair_rom_lat", lat2, 13);

        // Address wrap at the top of the 17-bit space.
        do_req(1, 1, 32'h0001FFFE, 32'h44332211, 4'b1111, lat, word, addrs, wrs);
        do_req(1, 0, 32'h0001FFFE, 0, 0, lat, word, addrs, wrs);
        chk("wrap_addrs", addrs, {17'h00001, 17'h00000, 17'h1FFFF, 17'h1FFFE});
        chk("wrap_word", word, 32'h44332211);

        // Reset in cycle 3 of a full store.
        @(posedge clk); #1;
        ram_ce = 1; ram_we = 1; ram_addr = 32'h500; ram_wd = 32'h11223344; ram_sel = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        rst = 1; ram_ce = 0;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_mem_wr", mem_wr, 0);
            chk("abort_no_ready", ram_ready, 0);
        end
        chk("abort_b0", ext_mem[17'h500], 8'h44);
        chk("abort_b1", ext_mem[17'h501], 8'h33);
        chk("abort_b2", ext_mem[17'h502], 8'h00);
        chk("abort_b3", ext_mem[17'h503], 8'h00);
        do_req(0, 0, 32'h500, 0, 0, lat, word, addrs, wrs);
        chk("post_abort_lat", lat, 6);
        chk("post_abort_word", word, 32'h00003344);

        // Randomized traffic; every cycle is checked by the model.
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a[AW-1:0] = 17'h1FFFC + AW'($urandom_range(0, 3));
            else a[AW-1:0] = AW'($urandom_range(0, 255));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case (kind)
                0: begin
                    do_req(0, 0, a, 0, 0, lat, word, addrs, wrs);
                    chk("rnd_fetch_lat", lat, 6);
                end
                1: begin
                    do_req(1, 0, a, d, s, lat, word, addrs, wrs);
                    chk("rnd_load_lat", lat, 6);
                end
                2: begin
                    do_req(1, 1, a, d, s, lat, word, addrs, wrs);
                    chk("rnd_store_lat", lat, 5);
                    chk("rnd_store_wrs", wrs, s);
                end
                default: begin
                    kind = $urandom_range(0, 1);
                    do_pair(kind[0], a, d, s, $urandom, lat, lat2);
                    chk("rnd_pair_ram_lat", lat, kind[0] ? 5 : 6);
                    chk("rnd_pair_rom_lat", lat2, kind[0] ? 12 : 13);
                end
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
